// File: rtl/gpio_multi.sv
// Multi-port GPIO: synchronised inputs, write-only-via-bus output registers, optional change IRQ (GPIO_IRQ_EN).
// Latency: inputs visible on rd SYNC_STAGES edges after change; writes visible after one edge; rd and irq are combinational.
// Backpressure: none, every access completes in a single cycle.
module gpio_multi #(
   parameter int WIDTH       = 32,
   parameter int N_IN        = 2,
   parameter int N_OUT       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int AW          = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [AW-1:0]          a,
   input  logic [WIDTH-1:0]       wd,
   output logic [WIDTH-1:0]       rd,
   input  logic [N_IN*WIDTH-1:0]  gpI,
   output logic [N_OUT*WIDTH-1:0] gpO,
   output logic                   irq
);

   logic [SYNC_STAGES-1:0][N_IN-1:0][WIDTH-1:0] sync_q;
   logic [N_IN-1:0][WIDTH-1:0]                  sync_last;
   logic [N_OUT-1:0][WIDTH-1:0]                 out_q;

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign gpO       = out_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         out_q  <= '0;
      end else begin
         sync_q[0] <= gpI;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         for (int j = 0; j < N_OUT; j++) begin
            if (we && (a == AW'(N_IN + j))) begin
               out_q[j] <= wd;
            end
         end
      end
   end

`ifdef GPIO_IRQ_EN
   localparam logic [AW-1:0] STAT_A = AW'(N_IN + N_OUT);
   localparam logic [AW-1:0] MASK_A = AW'(N_IN + N_OUT + 1);

   logic [N_IN-1:0][WIDTH-1:0] prev_q;
   logic [N_IN-1:0]            status_q;
   logic [N_IN-1:0]            mask_q;
   logic [N_IN-1:0]            chg;
   logic [N_IN-1:0]            clr;

   always_comb begin
      chg = '0;
      clr = '0;
      for (int i = 0; i < N_IN; i++) begin
         chg[i] = |(sync_last[i] ^ prev_q[i]);
      end
      if (we && (a == STAT_A)) begin
         clr = N_IN'(wd);
      end
   end

   // Set is OR-ed in after the clear so a same-cycle change is never lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q   <= '0;
         status_q <= '0;
         mask_q   <= '0;
      end else begin
         prev_q   <= sync_last;
         status_q <= (status_q & ~clr) | chg;
         if (we && (a == MASK_A)) begin
            mask_q <= N_IN'(wd);
         end
      end
   end

   assign irq = |(status_q & mask_q);
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (a == AW'(i)) rd = sync_last[i];
      end
      for (int j = 0; j < N_OUT; j++) begin
         if (a == AW'(N_IN + j)) rd = out_q[j];
      end
`ifdef GPIO_IRQ_EN
      if (a == STAT_A) rd = WIDTH'(status_q);
      if (a == MASK_A) rd = WIDTH'(mask_q);
`endif
   end

endmodule

// File: tb/tb_gpio_multi.sv
// Scoreboard bench for gpio_multi at default parameters; IRQ checks compile in with GPIO_IRQ_EN.
module tb_gpio_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [2:0]  a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic [63:0] gpI;
   logic [63:0] gpO;
   logic        irq;

   int n_vec = 0;
   int n_bad = 0;

   int          kind_q[$];
   logic [63:0] exp_q[$];
   string       name_q[$];

   gpio_multi #(
      .WIDTH(32), .N_IN(2), .N_OUT(2), .SYNC_STAGES(2), .AW(3)
   ) dut (
      .clk(clk), .rst(rst), .we(we), .a(a), .wd(wd), .rd(rd),
      .gpI(gpI), .gpO(gpO), .irq(irq)
   );

   always #5 clk = ~clk;

   // kind: 0 = rd, 1 = gpO, 2 = irq
   task automatic chk(input int k, input logic [63:0] v, input string n);
      kind_q.push_back(k);
      exp_q.push_back(v);
      name_q.push_back(n);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      int          k;
      logic [63:0] e;
      logic [63:0] act;
      string       n;
      while (kind_q.size() > 0) begin
         k = kind_q.pop_front();
         e = exp_q.pop_front();
         n = name_q.pop_front();
         case (k)
            0:       act = {32'h0, rd};
            1:       act = gpO;
            default: act = {63'h0, irq};
         endcase
         n_vec++;
         if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; we = 1'b0; a = 3'd0; wd = 32'h0;
      gpI = 64'hFFFF_FFFF_FFFF_FFFF;
      step(); step();
      chk(1, 64'h0, "rst_gpo");
      chk(2, 64'h0, "rst_irq");
      a = 3'd0; chk(0, 64'h0, "rst_rd_in0");
      step();
      a = 3'd1; chk(0, 64'h0, "rst_rd_in1");
      step();
      gpI = 64'h0;
      step();
      rst = 1'b1;
      step(); step(); step();

      // input synchroniser latency
      gpI[31:0] = 32'h1234_5678; a = 3'd0;
      chk(0, 64'h0, "sync_e0");
      step(); chk(0, 64'h0, "sync_e1");
      step(); chk(0, 64'h1234_5678, "sync_e2");
      step();

      // output register write and hold
      we = 1'b1; a = 3'd2; wd = 32'hDEAD_BEEF;
      step();
      we = 1'b0; wd = 32'h1;
      chk(1, 64'h0000_0000_DEAD_BEEF, "wr_out0_gpo");
      chk(0, 64'hDEAD_BEEF, "wr_out0_rd");
      step();
      chk(1, 64'h0000_0000_DEAD_BEEF, "we0_hold");
      step();

      // output port 1, writes to input and unmapped addresses ignored
      we = 1'b1; a = 3'd3; wd = 32'hFFFF_FFFF; step();
      a = 3'd0; wd = 32'h5;      step();
      a = 3'd6; wd = 32'hCAFE;   step();
      a = 3'd7; wd = 32'h1234;   step();
      we = 1'b0;
      chk(1, 64'hFFFF_FFFF_DEAD_BEEF, "out1_gpo");
      a = 3'd0; chk(0, 64'h1234_5678, "in0_ro"); step();
      a = 3'd6; chk(0, 64'h0, "unmapped6");      step();
      a = 3'd7; chk(0, 64'h0, "unmapped7");      step();
      a = 3'd3; chk(0, 64'hFFFF_FFFF, "out1_rd"); step();

      we = 1'b1; a = 3'd2; wd = 32'h0; step();
      we = 1'b0;
      chk(1, 64'hFFFF_FFFF_0000_0000, "out_indep");
      step();

      gpI[63:32] = 32'hA5A5_0001; a = 3'd1;
      step(); chk(0, 64'h0, "in1_e1");
      step(); chk(0, 64'hA5A5_0001, "in1_e2");
      step();

`ifndef GPIO_IRQ_EN
      we = 1'b1; a = 3'd4; wd = 32'hFFFF_FFFF; step();
      a = 3'd5; step();
      we = 1'b0;
      a = 3'd4; chk(0, 64'h0, "noirq_stat_rd"); chk(2, 64'h0, "noirq_irq"); step();
      a = 3'd5; chk(0, 64'h0, "noirq_mask_rd"); step();
`else
      a = 3'd4; chk(0, 64'h3, "stat_sticky"); chk(2, 64'h0, "irq_masked");
      step();
      we = 1'b1; a = 3'd4; wd = 32'h3;         step();
      a = 3'd5; wd = 32'hFFFF_FFF2;            step();
      we = 1'b0;
      a = 3'd5; chk(0, 64'h2, "mask_rd");      step();
      a = 3'd4; chk(0, 64'h0, "stat_clr_all"); chk(2, 64'h0, "irq_clr_all");
      step();

      gpI[32] = ~gpI[32];
      step(); chk(0, 64'h0, "stat_e1");
      step(); chk(0, 64'h0, "stat_e2"); chk(2, 64'h0, "irq_e2");
      step(); chk(0, 64'h2, "stat_e3"); chk(2, 64'h1, "irq_e3");
      step();
      we = 1'b1; a = 3'd4; wd = 32'h2; step();
      we = 1'b0;
      chk(0, 64'h0, "stat_w1c"); chk(2, 64'h0, "irq_w1c");
      step();

      for (int k = 0; k < 6; k++) begin
         gpI[32] = ~gpI[32];
         we = 1'b1; a = 3'd4; wd = 32'h2;
         step();
      end
      we = 1'b0;
      chk(0, 64'h2, "set_wins"); chk(2, 64'h1, "set_wins_irq");
      step();
      we = 1'b1; a = 3'd5; wd = 32'h0; step();
      we = 1'b0;
      chk(2, 64'h0, "mask0_irq");
      step();
      repeat (3) step();
      we = 1'b1; a = 3'd4; wd = 32'h3; step();
      we = 1'b0;
      chk(0, 64'h0, "stat_cleanup");
      step();
`endif

      // async reset in the middle of a write
      we = 1'b1; a = 3'd2; wd = 32'hA5A5_A5A5; step();
      we = 1'b0;
      chk(1, 64'hFFFF_FFFF_A5A5_A5A5, "pre_rst_gpo");
`ifdef GPIO_IRQ_EN
      we = 1'b1; a = 3'd5; wd = 32'h1; step();
      we = 1'b0;
      gpI[0] = ~gpI[0];
      repeat (3) step();
      a = 3'd4;
      chk(2, 64'h1, "pre_rst_irq"); chk(0, 64'h1, "pre_rst_stat");
`endif
      step();
      we = 1'b1; a = 3'd3; wd = 32'h1234_5678;
      #2;
      rst = 1'b0;
      chk(1, 64'h0, "arst_gpo");
      chk(2, 64'h0, "arst_irq");
      chk(0, 64'h0, "arst_rd");
      step();
      chk(1, 64'h0, "arst_write_lost");
      step();
      rst = 1'b1; we = 1'b0; a = 3'd4;
      step();
      chk(1, 64'h0, "post_rst_gpo");
      chk(0, 64'h0, "post_rst_stat");
      step();

      repeat (2) @(negedge clk);
      if (kind_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d checks pending, expected 0", kind_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
